// File: rtl/cmd_bus_turnaround_tracker.sv
// Channel-wide CAS turnaround tracker: publishes per-rank read/write "free" flags
// from the gap since the last issue, and latches a sticky flag on any illegal issue.
module cmd_bus_turnaround_tracker #(
  parameter int NUM_RANKS = 4,
  parameter int CNT_W     = 6,
  parameter int T_SAME    = 1,
  parameter int T_RTRS    = 2,
  parameter int T_RTW     = 8,
  parameter int T_WTR     = 6,
  parameter int RTRS_EN   = 1,
  localparam int RANK_W   = $clog2(NUM_RANKS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issueValid,
  input  logic [RANK_W-1:0]    issueRank,
  input  logic                 issueIsWrite,
  input  logic                 blockReq,
  output logic [NUM_RANKS-1:0] rdFree,
  output logic [NUM_RANKS-1:0] wrFree,
  output logic                 rankTransition,
  output logic [RANK_W-1:0]    lastRank,
  output logic                 lastIsWrite,
  output logic                 violation
);

  localparam logic [CNT_W-1:0] SINCE_MAX = '1;
  localparam logic [CNT_W-1:0] G_SAME    = CNT_W'(T_SAME);
  localparam logic [CNT_W-1:0] G_RTRS    = CNT_W'(T_RTRS);
  localparam logic [CNT_W-1:0] G_RTW     = CNT_W'(T_RTW);
  localparam logic [CNT_W-1:0] G_WTR     = CNT_W'(T_WTR);

  logic [CNT_W-1:0]  since_q, since_d;
  logic              has_history_q, has_history_d;
  logic [RANK_W-1:0] last_rank_q, last_rank_d;
  logic              last_is_write_q, last_is_write_d;
  logic              rank_trans_q, rank_trans_d;
  logic              violation_q, violation_d;
  logic              issue_ok;

  // Required gap is the larger of the direction gap and the rank-change gap.
  function automatic logic [CNT_W-1:0] req_gap(input logic rank_diff,
                                               input logic cand_wr,
                                               input logic prev_wr);
    logic [CNT_W-1:0] g_dir;
    logic [CNT_W-1:0] g_rank;
    if (cand_wr == prev_wr) begin
      g_dir = G_SAME;
    end else if (cand_wr) begin
      g_dir = G_RTW;
    end else begin
      g_dir = G_WTR;
    end
    g_rank = rank_diff ? G_RTRS : G_SAME;
    return (g_dir > g_rank) ? g_dir : g_rank;
  endfunction

  always_comb begin
    rdFree = '0;
    wrFree = '0;
    for (int r = 0; r < NUM_RANKS; r++) begin
      rdFree[r] = !blockReq && (!has_history_q ||
                  since_q >= req_gap((RANK_W'(r) != last_rank_q) && (RTRS_EN != 0),
                                     1'b0, last_is_write_q));
      wrFree[r] = !blockReq && (!has_history_q ||
                  since_q >= req_gap((RANK_W'(r) != last_rank_q) && (RTRS_EN != 0),
                                     1'b1, last_is_write_q));
    end
  end

  // Blocked flags count as "not free", so an issue under blockReq is a violation.
  assign issue_ok = issueIsWrite ? wrFree[issueRank] : rdFree[issueRank];

  always_comb begin
    since_d         = (since_q == SINCE_MAX) ? since_q : since_q + 1'b1;
    has_history_d   = has_history_q;
    last_rank_d     = last_rank_q;
    last_is_write_d = last_is_write_q;
    rank_trans_d    = 1'b0;
    violation_d     = violation_q;
    if (issueValid) begin
      since_d         = CNT_W'(1);
      has_history_d   = 1'b1;
      last_rank_d     = issueRank;
      last_is_write_d = issueIsWrite;
      rank_trans_d    = has_history_q && (issueRank != last_rank_q);
      violation_d     = violation_q || !issue_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      since_q         <= SINCE_MAX;
      has_history_q   <= 1'b0;
      last_rank_q     <= '0;
      last_is_write_q <= 1'b0;
      rank_trans_q    <= 1'b0;
      violation_q     <= 1'b0;
    end else begin
      since_q         <= since_d;
      has_history_q   <= has_history_d;
      last_rank_q     <= last_rank_d;
      last_is_write_q <= last_is_write_d;
      rank_trans_q    <= rank_trans_d;
      violation_q     <= violation_d;
    end
  end

  assign rankTransition = rank_trans_q;
  assign lastRank       = last_rank_q;
  assign lastIsWrite    = last_is_write_q;
  assign violation      = violation_q;

endmodule

// File: tb/tb_cmd_bus_turnaround_tracker.sv
// Bench for cmd_bus_turnaround_tracker: table of per-cycle vectors on a default
// instance plus a short hand sequence on a single-rank-mode (RTRS_EN=0) instance.
module tb_cmd_bus_turnaround_tracker;
  localparam int NR = 4;
  localparam int RW = 2;
  localparam int W  = 13;
  localparam logic [3:0] ALL  = 4'hF;
  localparam logic [3:0] NONE = 4'h0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          a_iv, a_wr, a_blk;
  logic [RW-1:0] a_rank;
  logic [NR-1:0] a_rd, a_wrf;
  logic          a_rt, a_lw, a_v;
  logic [RW-1:0] a_lr;

  logic          b_iv, b_wr, b_blk;
  logic [RW-1:0] b_rank;
  logic [NR-1:0] b_rd, b_wrf;
  logic          b_rt, b_lw, b_v;
  logic [RW-1:0] b_lr;

  cmd_bus_turnaround_tracker dut_a (
    .clk(clk), .rst(rst), .issueValid(a_iv), .issueRank(a_rank),
    .issueIsWrite(a_wr), .blockReq(a_blk), .rdFree(a_rd), .wrFree(a_wrf),
    .rankTransition(a_rt), .lastRank(a_lr), .lastIsWrite(a_lw), .violation(a_v)
  );

  cmd_bus_turnaround_tracker #(.RTRS_EN(0)) dut_b (
    .clk(clk), .rst(rst), .issueValid(b_iv), .issueRank(b_rank),
    .issueIsWrite(b_wr), .blockReq(b_blk), .rdFree(b_rd), .wrFree(b_wrf),
    .rankTransition(b_rt), .lastRank(b_lr), .lastIsWrite(b_lw), .violation(b_v)
  );

  typedef struct {
    logic          rst_n;
    logic          iv;
    logic [RW-1:0] rank;
    logic          wr;
    logic          blk;
    logic [W-1:0]  exp;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  // Expected-output word layout: {rdFree, wrFree, rankTransition, lastRank, lastIsWrite, violation}
  function automatic logic [W-1:0] pk(input logic [3:0] rd, input logic [3:0] wr,
                                      input logic rt, input logic [1:0] lr,
                                      input logic lw, input logic v);
    return {rd, wr, rt, lr, lw, v};
  endfunction

  task automatic add(input logic rst_n, input logic iv, input logic [RW-1:0] rank,
                     input logic wr, input logic blk, input logic [W-1:0] exp);
    vec_t v;
    v.rst_n = rst_n; v.iv = iv; v.rank = rank; v.wr = wr; v.blk = blk; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [W-1:0] act);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    n_cmp++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s[%0d]: got rd=%b wr=%b rt=%b lr=%0d lw=%b v=%b, want rd=%b wr=%b rt=%b lr=%0d lw=%b v=%b",
               name, idx, act[12:9], act[8:5], act[4], act[3:2], act[1], act[0],
               e[12:9], e[8:5], e[4], e[3:2], e[1], e[0]);
    end
  endtask

  // Drives one cycle on dut_b at a negedge and compares its outputs in the same cycle.
  task automatic b_step(input int idx, input logic iv, input logic [RW-1:0] rank,
                        input logic wr, input logic [W-1:0] exp);
    b_iv = iv; b_rank = rank; b_wr = wr; b_blk = 1'b0;
    exp_q.push_back(exp);
    #1;
    check("single_rank", idx, {b_rd, b_wrf, b_rt, b_lr, b_lw, b_v});
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    a_iv = 1'b0; a_rank = '0; a_wr = 1'b0; a_blk = 1'b0;
    b_iv = 1'b0; b_rank = '0; b_wr = 1'b0; b_blk = 1'b0;

    // Reset and idle
    add(1, 0, 0, 0, 0, pk(ALL, ALL, 0, 0, 0, 0));
    add(1, 0, 0, 0, 0, pk(ALL, ALL, 0, 0, 0, 0));
    // Read r0, then read r1 two cycles later
    add(1, 1, 0, 0, 0, pk(ALL, ALL, 0, 0, 0, 0));
    add(1, 0, 0, 0, 0, pk(4'b0001, NONE, 0, 0, 0, 0));
    add(1, 1, 1, 0, 0, pk(ALL, NONE, 0, 0, 0, 0));
    add(1, 0, 0, 0, 0, pk(4'b0010, NONE, 1, 1, 0, 0));
    for (int k = 0; k < 6; k++) add(1, 0, 0, 0, 0, pk(ALL, NONE, 0, 1, 0, 0));
    // tRTW met exactly; write r2, then legal read r3 at +6
    add(1, 1, 2, 1, 0, pk(ALL, ALL, 0, 1, 0, 0));
    add(1, 0, 0, 0, 0, pk(NONE, 4'b0100, 1, 2, 1, 0));
    for (int k = 0; k < 4; k++) add(1, 0, 0, 0, 0, pk(NONE, ALL, 0, 2, 1, 0));
    add(1, 1, 3, 0, 0, pk(ALL, ALL, 0, 2, 1, 0));
    add(1, 0, 0, 0, 0, pk(4'b1000, NONE, 1, 3, 0, 0));
    for (int k = 0; k < 6; k++) add(1, 0, 0, 0, 0, pk(ALL, NONE, 0, 3, 0, 0));
    // Write r2, illegal read r2 at +3, sticky violation, then reset mid-gap
    add(1, 1, 2, 1, 0, pk(ALL, ALL, 0, 3, 0, 0));
    add(1, 0, 0, 0, 0, pk(NONE, 4'b0100, 1, 2, 1, 0));
    add(1, 0, 0, 0, 0, pk(NONE, ALL, 0, 2, 1, 0));
    add(1, 1, 2, 0, 0, pk(NONE, ALL, 0, 2, 1, 0));
    add(1, 0, 0, 0, 0, pk(4'b0100, NONE, 0, 2, 0, 1));
    for (int k = 0; k < 4; k++) add(1, 0, 0, 0, 0, pk(ALL, NONE, 0, 2, 0, 1));
    add(0, 0, 0, 0, 0, pk(ALL, NONE, 0, 2, 0, 1));
    add(1, 0, 0, 0, 0, pk(ALL, ALL, 0, 0, 0, 0));
    // blockReq hold, release, then issue under blockReq
    for (int k = 0; k < 3; k++) add(1, 0, 0, 0, 1, pk(NONE, NONE, 0, 0, 0, 0));
    add(1, 0, 0, 0, 0, pk(ALL, ALL, 0, 0, 0, 0));
    add(1, 1, 1, 0, 1, pk(NONE, NONE, 0, 0, 0, 0));
    add(1, 0, 0, 0, 0, pk(4'b0010, NONE, 0, 1, 0, 1));
    add(1, 0, 0, 0, 0, pk(ALL, NONE, 0, 1, 0, 1));
    add(0, 0, 0, 0, 0, pk(ALL, NONE, 0, 1, 0, 1));
    // Write r3 then 70 idle cycles: counter saturates at 63 and must not wrap
    add(1, 1, 3, 1, 0, pk(ALL, ALL, 0, 0, 0, 0));
    for (int k = 0; k < 70; k++) begin
      int s;
      s = (k + 1 > 63) ? 63 : k + 1;
      add(1, 0, 0, 0, 0, pk((s >= 6) ? ALL : NONE, (s >= 2) ? ALL : 4'b1000, 0, 3, 1, 0));
    end
    // Write r0 after saturation, then reset one cycle into the gap
    add(1, 1, 0, 1, 0, pk(ALL, ALL, 0, 3, 1, 0));
    add(1, 0, 0, 0, 0, pk(NONE, 4'b0001, 1, 0, 1, 0));
    add(0, 0, 0, 0, 0, pk(NONE, ALL, 0, 0, 1, 0));
    add(1, 0, 0, 0, 0, pk(ALL, ALL, 0, 0, 0, 0));

    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst_n;
      a_iv = vecs[i].iv; a_rank = vecs[i].rank; a_wr = vecs[i].wr; a_blk = vecs[i].blk;
      exp_q.push_back(vecs[i].exp);
      #1;
      check("vec", i, {a_rd, a_wrf, a_rt, a_lr, a_lw, a_v});
      @(negedge clk);
    end
    a_iv = 1'b0; a_blk = 1'b0; rst = 1'b1;

    // Single-rank mode: rank change needs no extra gap, turnaround gaps still apply
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    b_step(0, 1, 0, 0, pk(ALL, ALL, 0, 0, 0, 0));
    b_step(1, 1, 1, 0, pk(ALL, NONE, 0, 0, 0, 0));
    b_step(2, 0, 0, 0, pk(ALL, NONE, 1, 1, 0, 0));
    b_step(3, 1, 0, 1, pk(ALL, NONE, 0, 1, 0, 0));
    b_step(4, 0, 0, 0, pk(NONE, ALL, 1, 0, 1, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cmd_bus_turnaround_tracker.md
# cmd_bus_turnaround_tracker

Parametrised channel-wide tracker for CMD/data-bus turnaround timing. It generalises rank-to-rank turnaround (tRTRS) to N ranks and adds read-to-write (tRTW) and write-to-read (tWTR) constraints. Each cycle it publishes per-rank, per-direction "free" flags that the ChannelController uses to gate CMD grants from CMDGrantScheduler. It also flags any issue that violates those flags. It performs no arbitration.

## Interface
- NUM_RANKS, 4: ranks on the channel; must be ≥ 2 and a power of 2.
- CNT_W, 6: elapsed-cycle counter width. Every gap parameter must be ≤ 2^CNT_W − 1.
- T_SAME, 1: minimum gap for same rank and same direction. 1 means back-to-back is allowed.
- T_RTRS, 2: minimum gap for a rank change with the same direction.
- T_RTW, 8: minimum gap for read followed by write on the same rank.
- T_WTR, 6: minimum gap for write followed by read on the same rank.
- RTRS_EN, 1: when 0, the rank-change gap is ignored (single-rank mode). Turnaround gaps still apply.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- issueValid  in  1  a CAS command is issued on the bus this cycle.
- issueRank  in  $clog2(NUM_RANKS)  rank of the issued command.
- issueIsWrite  in  1  1 = write CAS, 0 = read CAS.
- blockReq  in  1  external hold, e.g. refresh. Forces all free flags low combinationally.
- rdFree  out  NUM_RANKS  bit r: a read to rank r may issue this cycle.
- wrFree  out  NUM_RANKS  bit r: a write to rank r may issue this cycle.
- rankTransition  out  1  registered one-cycle pulse after an issue whose rank differs from the previous issue.
- lastRank  out  $clog2(NUM_RANKS)  rank of the most recent issue.
- lastIsWrite  out  1  direction of the most recent issue.
- violation  out  1  sticky flag: an issue occurred whose free flag was 0.

## Operation

**State registers**
- since: elapsed-cycle counter, CNT_W bits.
- hasHistory.
- lastRank.
- lastIsWrite.
- violation.
- rankTransition.

**Elapsed counter**
- since counts cycles since the last issue.
- On an issueValid cycle: since ← 1.
- Otherwise: since ← since + 1, saturating at 2^CNT_W − 1. It never wraps.

**Required gap g(r, w)** for a candidate issue to rank r with direction w:
- dRank = (r ≠ lastRank) && RTRS_EN.
- dDir = (w ≠ lastIsWrite).
- gDir = T_SAME if !dDir; T_RTW if (w && !lastIsWrite); T_WTR if (!w && lastIsWrite).
- g = max(gDir, dRank ? T_RTRS : T_SAME).

**Free flags**
- rdFree[r] = !blockReq && (!hasHistory || since ≥ g(r,0)).
- wrFree[r] = !blockReq && (!hasHistory || since ≥ g(r,1)).
- Both are purely combinational from registered state plus blockReq.

**On issueValid**
- lastRank ← issueRank.
- lastIsWrite ← issueIsWrite.
- hasHistory ← 1.
- rankTransition ← hasHistory && (issueRank ≠ lastRank); otherwise rankTransition ← 0. This is independent of RTRS_EN.
- If the matching free flag (rdFree[issueRank] or wrFree[issueRank]) is 0 in that cycle, violation ← 1. This includes free flags forced low by blockReq.
- An illegal issue still updates all state.

**Clearing**
- violation clears only on reset.

## Timing

**Reset values** (rst = 0 at a clk edge):
- since = 2^CNT_W − 1.
- hasHistory = 0.
- lastRank = 0.
- lastIsWrite = 0.
- rankTransition = 0.
- violation = 0.
- Therefore rdFree/wrFree read all-ones unless blockReq is high.

**Reset mid-operation**
- Any pending gap is discarded; all ranks are free the next cycle.

**Latency**
- An issue at cycle t restricts the free flags from cycle t+1.
- A candidate with gap g becomes free at cycle t+g, i.e. after g−1 idle cycles.
- rankTransition is high in cycle t+1 only.

**Boundary conditions**
- Back-to-back issues reload since each cycle. Gaps are always measured from the latest issue only.
- Saturated since satisfies every legal gap.
- blockReq has no effect on state. Deasserting it restores the flags the same cycle.
- An issue while blockReq is high sets violation.

## Test plan
- Reset, then idle → rdFree = wrFree = 4'b1111, violation = 0, rankTransition = 0.
- Read rank 0 at t; no further issues → rdFree[0] = 1 at t+1; rdFree[1..3] = 0 at t+1, 1 at t+2; wrFree[0] = 0 until t+8. Then issue read rank 1 at t+2 → rankTransition = 1 at t+3 only, violation stays 0.
- Write rank 2 at t, read rank 2 at t+3 → violation = 1 from t+4 and stays set through further idle cycles. Read rank 3 at t+6 with a fresh write at t → legal: gap = max(6, 2) = 6, violation stays 0.
- RTRS_EN = 0: read rank 0 at t, then read rank 1 at t+1 → legal. rankTransition still pulses at t+2.
- blockReq high for 3 cycles with no issues → all free flags 0 during the hold, restored on the same cycle blockReq falls. An issue during blockReq → violation = 1.
- Issue a write, hold 70 idle cycles (CNT_W = 6) → since saturates at 63, no wrap, all flags 1. Assert rst for one cycle mid-gap → all free = 1 and violation = 0 next cycle.
